// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard and its per-port lookup.
package fwd_scoreboard_pkg;

    // Select value that means "take the register-file read data".
    localparam int SEL_RF = 0;

    // Per-entry status record. rd/data widths follow the module parameters, so they are kept beside it.
    typedef struct packed {
        logic valid;
        logic dvld;
    } entry_flags_t;

    function automatic int sel_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Priority match of one operand address against the in-flight producer entries.
module fwd_lookup
    import fwd_scoreboard_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SW     = 2
) (
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [WIDTH-1:0]        rf_data_i,
    input  logic [DEPTH-1:0]        vld_i,
    input  logic [DEPTH-1:0]        dvld_i,
    input  logic [DEPTH*ADDR_W-1:0] rd_i,
    input  logic [DEPTH*WIDTH-1:0]  data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [SW-1:0]           sel_o,
    output logic                    stall_o
);

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        data_o  = rf_data_i;
        sel_o   = SW'(SEL_RF);
        stall_o = 1'b0;
        if (addr_i != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (vld_i[k] && (rd_i[k*ADDR_W +: ADDR_W] == addr_i)) begin
                    data_o  = data_i[k*WIDTH +: WIDTH];
                    sel_o   = SW'(k + 1);
                    stall_o = ~dvld_i[k];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Tracks in-flight producer results and forwards them to NRD operand read ports.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int NRD    = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                advance_i,
    input  logic                                flush_i,
    input  logic                                iss_vld_i,
    input  logic [ADDR_W-1:0]                   iss_rd_i,
    input  logic [WIDTH-1:0]                    iss_data_i,
    input  logic                                iss_dvld_i,
    input  logic                                fill_vld_i,
    input  logic [$clog2(DEPTH)-1:0]            fill_stage_i,
    input  logic [WIDTH-1:0]                    fill_data_i,
    input  logic [NRD*ADDR_W-1:0]               rd_addr_i,
    input  logic [NRD*WIDTH-1:0]                rd_data_i,
    output logic [NRD*WIDTH-1:0]                fw_data_o,
    output logic [NRD*$clog2(DEPTH+1)-1:0]      fw_sel_o,
    output logic                                stall_o
);

    localparam int FSW = $clog2(DEPTH);
    localparam int SW  = sel_bits(DEPTH);

    entry_flags_t [DEPTH-1:0]             flags_q, flags_d;
    logic         [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
    logic         [DEPTH-1:0][WIDTH-1:0]  data_q, data_d;

    logic [DEPTH-1:0] vld_vec;
    logic [DEPTH-1:0] dvld_vec;
    logic [NRD-1:0]   port_stall;

    always_comb begin
        flags_d = flags_q;
        rd_d    = rd_q;
        data_d  = data_q;

        if (advance_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                flags_d[k] = flags_q[k-1];
                rd_d[k]    = rd_q[k-1];
                data_d[k]  = data_q[k-1];
            end
            flags_d[0].valid = iss_vld_i && (iss_rd_i != '0);
            flags_d[0].dvld  = iss_dvld_i;
            rd_d[0]          = iss_rd_i;
            data_d[0]        = iss_data_i;
        end

        // The fill names a pre-clock entry; on advance it lands where that entry moves to.
        if (fill_vld_i) begin
            if (!advance_i) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if ((fill_stage_i == FSW'(k)) && flags_q[k].valid) begin
                        data_d[k]       = fill_data_i;
                        flags_d[k].dvld = 1'b1;
                    end
                end
            end else begin
                for (int k = 1; k < DEPTH; k++) begin
                    if ((fill_stage_i == FSW'(k - 1)) && flags_q[k-1].valid) begin
                        data_d[k]       = fill_data_i;
                        flags_d[k].dvld = 1'b1;
                    end
                end
            end
        end

        if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                flags_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Payload is qualified by the valid flags, so it carries no reset.
    always_ff @(posedge clk_i) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flags
            assign vld_vec[gi]  = flags_q[gi].valid;
            assign dvld_vec[gi] = flags_q[gi].dvld;
        end

        for (gi = 0; gi < NRD; gi++) begin : g_port
            fwd_lookup #(
                .WIDTH  (WIDTH),
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH),
                .SW     (SW)
            ) u_lookup (
                .addr_i    (rd_addr_i[gi*ADDR_W +: ADDR_W]),
                .rf_data_i (rd_data_i[gi*WIDTH +: WIDTH]),
                .vld_i     (vld_vec),
                .dvld_i    (dvld_vec),
                .rd_i      (rd_q),
                .data_i    (data_q),
                .data_o    (fw_data_o[gi*WIDTH +: WIDTH]),
                .sel_o     (fw_sel_o[gi*SW +: SW]),
                .stall_o   (port_stall[gi])
            );
        end
    endgenerate

    assign stall_o = |port_stall;

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning forwarded data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 SHALL have parameter DEPTH, default 3, legal range 2..4, meaning number of tracked in-flight producer stages.
REQ-004 SHALL have parameter NRD, default 2, meaning number of read (operand) ports.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk_i  input  1  clock.
REQ-006 rst_i  input  1  asynchronous active-low reset.
REQ-007 advance_i  input  1  pipeline advances this cycle.
REQ-008 flush_i  input  1  synchronous invalidate of all entries.
REQ-009 iss_vld_i  input  1  producer entering stage 0 writes a register.
REQ-010 iss_rd_i  input  ADDR_W  destination of the entering producer.
REQ-011 iss_data_i  input  WIDTH  result of the entering producer.
REQ-012 iss_dvld_i  input  1  iss_data_i is valid (0 for loads).
REQ-013 fill_vld_i  input  1  late result available.
REQ-014 fill_stage_i  input  clog2(DEPTH)  entry index receiving the late result.
REQ-015 fill_data_i  input  WIDTH  late result value.
REQ-016 rd_addr_i  input  NRD*ADDR_W  packed operand addresses, port 0 in LSBs.
REQ-017 rd_data_i  input  NRD*WIDTH  packed register-file read data.
REQ-018 fw_data_o  output  NRD*WIDTH  packed forwarded operand data.
REQ-019 fw_sel_o  output  NRD*clog2(DEPTH+1)  per port: 0 = register file, k = entry k-1.
REQ-020 stall_o  output  1  an operand depends on a result not yet available.

Function
REQ-021 SHALL hold DEPTH entries, each {valid, rd, data, dvld}; entry 0 youngest.
REQ-022 On advance_i=1, entry k SHALL take entry k-1 (k>=1); entry DEPTH-1 contents SHALL be discarded.
REQ-023 On advance_i=1, entry 0 SHALL load valid = iss_vld_i AND iss_rd_i!=0, rd, data, dvld from iss_* inputs.
REQ-024 On advance_i=0, entries SHALL hold, except for fill.
REQ-025 fill_stage_i SHALL index pre-clock entries; without advance the fill writes data and sets dvld=1 on that entry; with advance it writes entry fill_stage_i+1, or is dropped if fill_stage_i=DEPTH-1.
REQ-026 Fill to an invalid entry SHALL be ignored.
REQ-027 flush_i=1 SHALL clear every valid bit at the clock edge, overriding advance, issue and fill.
REQ-028 Per port, fw_sel_o/fw_data_o SHALL be combinational: the lowest-index valid entry with rd equal to the port address wins; no match or address 0 -> sel 0 and rd_data_i.
REQ-029 stall_o SHALL be 1 in the same cycle if any port's winning entry has dvld=0; fw_data_o for that port is then don't-care.
REQ-030 The block SHALL NOT gate advance_i by stall_o; the pipeline controller owns that decision.

Reset
REQ-031 rst_i=0 SHALL asynchronously clear all valid and dvld bits; rd/data need no reset.
REQ-032 Out of reset, fw_sel_o SHALL be 0, fw_data_o SHALL equal rd_data_i, stall_o SHALL be 0.

Structure
REQ-033 A shared package SHALL hold the entry record type and the select encoding constant SEL_RF=0.
REQ-034 One sub-module, fwd_lookup (one per port, generated NRD times), SHALL implement the priority match of REQ-028/029.

Verification
REQ-035 Issue rd=5 data=0x11 dvld=1, advance; read port 0 addr 5 -> sel=1, data=0x11, stall=0.
REQ-036 Issue rd=5 0xAA then rd=5 0xBB with advances; read addr 5 -> sel=1, data=0xBB (youngest wins).
REQ-037 Issue load rd=7 dvld=0, advance; read addr 7 -> stall=1; fill stage 0 data 0x55, no advance -> next cycle sel=1, data=0x55, stall=0.
REQ-038 Issue rd=0 data=0xFF, advance; read addr 0 -> sel=0, data=rd_data_i.
REQ-039 Issue rd=3 then DEPTH further advances with no issue; read addr 3 -> sel=0 (aged out).
REQ-040 Fill 3 valid entries, pulse flush_i with advance_i=1 and iss_vld_i=1, then assert rst_i=0 mid-stream -> all reads sel=0, stall=0.
